// File: rtl/gray_counter_3bit_pkg.sv
// Shared code-conversion helpers: binary<->Gray functions and the counter step selector.
package gray_counter_3bit_pkg;

   localparam int unsigned GC_MAX_W = 16;

   typedef enum logic [1:0] {
      STEP_HOLD,
      STEP_LOAD,
      STEP_COUNT
   } step_e;

   // Narrower codes are zero-extended into GC_MAX_W bits; the upper bits stay zero.
   function automatic logic [GC_MAX_W-1:0] bin2gray(input logic [GC_MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [GC_MAX_W-1:0] gray2bin(input logic [GC_MAX_W-1:0] g);
      logic [GC_MAX_W-1:0] b;
      b = '0;
      b[GC_MAX_W-1] = g[GC_MAX_W-1];
      for (int unsigned i = GC_MAX_W - 1; i > 0; i--) begin
         b[i-1] = b[i] ^ g[i-1];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_counter_3bit_bin2gray.sv
// Combinational binary-to-Gray encoder of parameterised width.
module bin2gray_nbit
   import gray_counter_3bit_pkg::*;
#(
   parameter int unsigned WIDTH = 3
) (
   input  logic [WIDTH-1:0] i_bin,
   output logic [WIDTH-1:0] o_gray
);

   assign o_gray = WIDTH'(bin2gray(GC_MAX_W'(i_bin)));

endmodule

// File: rtl/gray_counter_3bit.sv
// Up/down binary counter with a registered Gray-code twin and a wrap pulse.
module gray_counter_3bit
   import gray_counter_3bit_pkg::*;
#(
   parameter int unsigned WIDTH    = 3,
   parameter int unsigned INIT_BIN = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_bin,
   output logic [WIDTH-1:0] bin_out,
   output logic [WIDTH-1:0] gray_out,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] INIT_B = WIDTH'(INIT_BIN);
   localparam logic [WIDTH-1:0] INIT_G = WIDTH'(bin2gray(GC_MAX_W'(INIT_B)));

   logic [WIDTH-1:0] r_bin;
   logic [WIDTH-1:0] r_gray;
   logic             r_wrap;

   step_e            w_step;
   logic [WIDTH-1:0] w_bin_next;
   logic [WIDTH-1:0] w_gray_next;
   logic             w_wrap_next;

   always_comb begin
      w_step = STEP_HOLD;
      if (load) begin
         w_step = STEP_LOAD;
      end else if (en) begin
         w_step = STEP_COUNT;
      end
   end

   always_comb begin
      w_bin_next  = r_bin;
      w_wrap_next = 1'b0;
      unique case (w_step)
         STEP_LOAD:  w_bin_next = load_bin;
         STEP_COUNT: begin
            if (up) begin
               w_bin_next  = r_bin + WIDTH'(1);
               w_wrap_next = (r_bin == '1);
            end else begin
               w_bin_next  = r_bin - WIDTH'(1);
               w_wrap_next = (r_bin == '0);
            end
         end
         default:    w_bin_next = r_bin;
      endcase
   end

   // Gray is encoded from the next binary value so both registers update together.
   bin2gray_nbit #(.WIDTH(WIDTH)) u_bin2gray (
      .i_bin  (w_bin_next),
      .o_gray (w_gray_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bin  <= INIT_B;
         r_gray <= INIT_G;
         r_wrap <= 1'b0;
      end else begin
         r_bin  <= w_bin_next;
         r_gray <= w_gray_next;
         r_wrap <= w_wrap_next;
      end
   end

   assign bin_out  = r_bin;
   assign gray_out = r_gray;
   assign wrap     = r_wrap;

endmodule
